// File: rtl/piradip_stream_to_symbol_if.sv
// ----------------------------------------------------------------------------
// piradip_stream_to_symbol_if : word-in / symbol-out stream bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface piradip_stream_to_symbol_if #(
  parameter int WIDTH     = 32,
  parameter int SYM_WIDTH = 1,
  parameter int CW        = $clog2(WIDTH / SYM_WIDTH + 1)
);
  logic [WIDTH-1:0]     words_tdata;
  logic                 words_tvalid;
  logic                 words_tlast;
  logic                 words_tready;
  logic [SYM_WIDTH-1:0] sym_tdata;
  logic                 sym_tvalid;
  logic                 sym_tlast;
  logic                 sym_tready;
  logic                 align;
  logic                 empty;
  logic [CW-1:0]        sym_count;

  modport slave (
    input  words_tdata, words_tvalid, words_tlast,
    output words_tready,
    output sym_tdata, sym_tvalid, sym_tlast,
    input  sym_tready,
    input  align,
    output empty, sym_count
  );

  modport master (
    output words_tdata, words_tvalid, words_tlast,
    input  words_tready,
    input  sym_tdata, sym_tvalid, sym_tlast,
    output sym_tready,
    output align,
    input  empty, sym_count
  );
endinterface

`default_nettype wire

// File: rtl/piradip_stream_to_symbol.sv
// ----------------------------------------------------------------------------
// piradip_stream_to_symbol : serialises WIDTH-bit words into SYM_WIDTH symbols
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module piradip_stream_to_symbol #(
  parameter int WIDTH     = 32,
  parameter int SYM_WIDTH = 1,
  parameter int MSB_FIRST = 1
) (
  input  wire logic                  aclk,
  input  wire logic                  aresetn,
  piradip_stream_to_symbol_if.slave  bus
);
  localparam int N  = WIDTH / SYM_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  generate
    if ((SYM_WIDTH < 1) || ((WIDTH % SYM_WIDTH) != 0)) begin : g_bad_sym_width
      $error("SYM_WIDTH must divide WIDTH exactly");
    end
  endgenerate

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_next;
  logic [CW-1:0]    cnt;
  logic             last_q;
  logic             sym_hs;
  logic             word_acc;

  assign sym_hs   = (cnt != CNT_ZERO) & bus.sym_tready;
  // Reloading on the final symbol's handshake keeps back-to-back words gapless.
  assign bus.words_tready = ~bus.align &
                            ((cnt == CNT_ZERO) | ((cnt == CNT_ONE) & sym_hs));
  assign word_acc = bus.words_tvalid & bus.words_tready;

  assign bus.sym_tvalid = (cnt != CNT_ZERO);
  assign bus.empty      = (cnt == CNT_ZERO);
  assign bus.sym_tlast  = (cnt == CNT_ONE) & last_q;
  assign bus.sym_count  = cnt;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign bus.sym_tdata = shift_q[WIDTH-1 -: SYM_WIDTH];
      assign shift_next    = shift_q << SYM_WIDTH;
    end else begin : g_lsb_first
      assign bus.sym_tdata = shift_q[SYM_WIDTH-1:0];
      assign shift_next    = shift_q >> SYM_WIDTH;
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      shift_q <= '0;
      cnt     <= CNT_ZERO;
      last_q  <= 1'b0;
    end else if (bus.align) begin
      cnt    <= CNT_ZERO;
      last_q <= 1'b0;
    end else if (word_acc) begin
      shift_q <= bus.words_tdata;
      cnt     <= CNT_FULL;
      last_q  <= bus.words_tlast;
    end else if (sym_hs) begin
      shift_q <= shift_next;
      cnt     <= cnt - CNT_ONE;
    end
  end
endmodule

`default_nettype wire
